// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle resolution of div-by-zero/overflow.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic [1:0]      state_o
);

   // Handshake: an op is accepted on the edge where state is IDLE, start_i=1 and
   // flush_i=0; stall_o holds upstream from that cycle through CALC; result_valid_o is
   // high for the single DONE cycle (unless flushed), when result_o/rd_o are valid.
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       count;
   logic [2:0]          f3_q;
   logic [4:0]          rd_q;
   logic [XLEN-1:0]     opnd;
   logic [2*XLEN-1:0]   acc;
   logic                neg_res, neg_rem;
   logic [XLEN-1:0]     result_q;
   logic [4:0]          rd_out_q;

   logic                rs1_sgn, rs2_sgn, a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                div_zero, div_ovf, special;
   logic [XLEN-1:0]     special_res;
   logic                accept;

   always_comb begin
      rs1_sgn = 1'b0;
      rs2_sgn = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            rs1_sgn = 1'b1;
            rs2_sgn = 1'b1;
         end
         3'b010:  rs1_sgn = 1'b1;
         default: ;
      endcase
   end

   assign a_neg    = rs1_sgn & rs1_i[XLEN-1];
   assign b_neg    = rs2_sgn & rs2_i[XLEN-1];
   assign a_mag    = a_neg ? -rs1_i : rs1_i;
   assign b_mag    = b_neg ? -rs2_i : rs2_i;
   assign div_zero = funct3_i[2] & (rs2_i == '0);
   assign div_ovf  = funct3_i[2] & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (rs2_i == '1);
   assign special  = div_zero | div_ovf;
   // funct3[1] separates REM/REMU from DIV/DIVU.
   assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                                 : (funct3_i[1] ? '0 : rs1_i);
   assign accept   = (state == IDLE) & start_i & ~flush_i;

   logic [XLEN-1:0]   hi, lo;
   logic [XLEN:0]     mul_sum, div_shl, div_diff;
   logic              qbit;
   logic [2*XLEN-1:0] acc_nxt, prod;
   logic [XLEN-1:0]   quot, remd, calc_res;

   assign hi       = acc[2*XLEN-1:XLEN];
   assign lo       = acc[XLEN-1:0];
   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign div_shl  = {hi, lo[XLEN-1]};
   assign div_diff = div_shl - {1'b0, opnd};
   assign qbit     = ~div_diff[XLEN];
   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
   assign acc_nxt  = f3_q[2] ? {(qbit ? div_diff[XLEN-1:0] : div_shl[XLEN-1:0]), lo[XLEN-2:0], qbit}
                             : {mul_sum, lo[XLEN-1:1]};
   assign prod     = neg_res ? -acc_nxt : acc_nxt;
   assign quot     = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
   assign remd     = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

   always_comb begin
      calc_res = '0;
      case (f3_q)
         3'b000:                 calc_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         calc_res = quot;
         default:                calc_res = remd;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      case (state)
         IDLE: if (accept) begin
            stall_o   = 1'b1;
            state_nxt = special ? DONE : CALC;
         end
         CALC: begin
            stall_o = 1'b1;
            if (count == CW'(1)) state_nxt = DONE;
         end
         DONE: begin
            result_valid_o = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush_i) begin
         state_nxt      = IDLE;
         result_valid_o = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         opnd     <= '0;
         acc      <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else if (accept) begin
         count   <= CW'(XLEN);
         f3_q    <= funct3_i;
         rd_q    <= rd_i;
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
         opnd    <= funct3_i[2] ? b_mag : a_mag;
         acc     <= funct3_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
         if (special) begin
            result_q <= special_res;
            rd_out_q <= rd_i;
         end
      end else if (state == CALC && !flush_i) begin
         acc   <= acc_nxt;
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            result_q <= calc_res;
            rd_out_q <= rd_q;
         end
      end
   end

   assign result_o = result_q;
   assign rd_o     = rd_out_q;
   assign state_o  = state;

endmodule
